mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Pipeline MEM stage of the RV32I core: sits between EX_MEM and MEM_WB.
//  Non-memory ops pass straight through; loads/stores run a request/done
//  handshake with the memory controller and hold the pipeline meanwhile.
//  Loads are sign/zero-extended; the result is held until MEM_WB captures it.
// PARAMETERS
//  ADDR_W  32  memory address width
//  DATA_W  32  register/data width (only 32 supported)
// PORTS
//  clk_in         in   1   clock, all state on posedge
//  rst_in         in   1   reset, asynchronous, active-low
//  rdy_in         in   1   global ready; low = freeze all state
//  stall_in       in   6   stall vector from stall ctrl; bit 4 = MEM_WB hold
//  ex_reg_addr    in   5   destination register
//  ex_reg_data    in   32  ALU result (non-memory ops)
//  ex_if_write    in   1   register write enable
//  ex_mem_op      in   4   MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW
//  ex_mem_addr    in   32  effective address
//  ex_store_data  in   32  store data (rs2)
//  stall_req_mem  out  1   stall request to stall ctrl
//  mc_req         out  1   memory request, level
//  mc_we          out  1   1 = store
//  mc_addr        out  32  request address
//  mc_len         out  2   bytes-1 (0=byte, 1=half, 3=word)
//  mc_wdata       out  32  store data, LSB-aligned
//  mc_done        in   1   one-cycle completion pulse
//  mc_rdata       in   32  load data, LSB-aligned, valid with mc_done
//  mem_reg_addr   out  5   to MEM_WB: destination register
//  mem_reg_data   out  32  to MEM_WB: writeback data
//  if_write       out  1   to MEM_WB: write enable
// BEHAVIOUR
//  - Reset (rst_in=0, async): state IDLE, mc_req/mc_we=0, mc_addr/mc_wdata/
//    mc_len=0, latched result 0; comb outputs then give stall_req_mem=0.
//  - rdy_in=0: no register changes; outputs hold current values.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE, op=MEM_NOP: combinational pass-through ex_reg_* -> mem_reg_*,
//    ex_if_write -> if_write; stall_req_mem=0; zero added latency.
//  - IDLE, memory op: stall_req_mem=1 same cycle (comb); outputs bubble
//    (addr/data 0, if_write 0). At edge: latch op, rd, store data; mc_req<=1,
//    mc_we, mc_addr, mc_len, mc_wdata (SB: data[7:0], SH: data[15:0]) -> BUSY.
//  - BUSY: mc_req/mc_addr/mc_we/mc_len/mc_wdata stable; stall_req_mem=1,
//    bubble out. On mc_done=1: latch extended mc_rdata (LB/LH sign-extend,
//    LBU/LHU zero-extend, LW as-is; stores latch 0), mc_req<=0 -> DONE.
//  - DONE: stall_req_mem=0; outputs latched rd/data; if_write=1 for loads
//    with rd!=0, 0 for stores. If stall_in[4]=0 && rdy_in -> IDLE (MEM_WB and
//    EX_MEM advance on the same edge, so the op is never re-issued);
//    otherwise hold DONE.
//  - mc_done outside BUSY ignored. Misaligned addresses passed unchanged.
//  - rd=x0 loads still access memory; if_write forced 0.
//  - Reset mid-BUSY drops mc_req; memory controller aborts on req falling.
// STRUCTURE
//  - define.v: MEM_* op encodings, LEN_* codes, FSM state codes; reuse
//    RstEnable/ZeroWorld/False/RegBus/RegAddrBus.
//  - One sub-module: load_extend (combinational op + rdata -> 32-bit value).
//  - FSM and request registers inline; output mux combinational.
// TESTING
//  1 ADD rd=5 data=0x1234 op=NOP -> same cycle mem_reg_addr=5,
//    mem_reg_data=0x1234, if_write=1, stall_req_mem=0, mc_req never high.
//  2 LB addr=0x100, mc_done after 3 cycles with rdata=0x80 -> stall 4 cycles,
//    mc_len=0, then data=0xFFFFFF80; LBU same -> 0x00000080.
//  3 SH addr=0x202 data=0xDEADBEEF -> mc_we=1, mc_len=1, mc_wdata=0x0000BEEF,
//    if_write=0 in DONE.
//  4 LW held in DONE with stall_in[4]=1 for 2 cycles -> outputs stable, no
//    second mc_req; released -> IDLE, next op taken the following cycle.
//  5 rdy_in=0 during BUSY with mc_done pulse masked -> no state change; done
//    taken after rdy_in returns.
//  6 rst_in low mid-BUSY -> mc_req=0 and if_write=0 immediately; after
//    release IDLE, no spurious request.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: memory op encodings, access length codes,
// FSM states and small decode helpers used by the stage and its extender.
package mem_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    // mc_len carries bytes-1 so the controller can use it as a byte-lane count
    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load(input mem_op_e op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic [1:0] op_len(input mem_op_e op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return LEN_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: return LEN_HALF;
            default:                 return LEN_WORD;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] align_wdata(input mem_op_e op,
                                                    input logic [XLEN-1:0] data);
        case (op)
            MEM_SB:  return {24'b0, data[7:0]};
            MEM_SH:  return {16'b0, data[15:0]};
            MEM_SW:  return data;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Combinational load-data extender: turns LSB-aligned memory read data into
// the 32-bit register value for the given load op; stores and NOP yield 0.
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  mem_op_e         op_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data_o = '0;
        case (op_i)
            MEM_LB:  data_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
            MEM_LBU: data_o = {24'b0, rdata_i[7:0]};
            MEM_LH:  data_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
            MEM_LHU: data_o = {16'b0, rdata_i[15:0]};
            MEM_LW:  data_o = rdata_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: passes non-memory ops straight through, runs a req/done
// handshake with the memory controller for loads/stores and holds the result.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [5:0]            stall_in,
    input  logic [REG_ADDR_W-1:0] ex_reg_addr,
    input  logic [DATA_W-1:0]     ex_reg_data,
    input  logic                  ex_if_write,
    input  logic [3:0]            ex_mem_op,
    input  logic [ADDR_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_store_data,
    output logic                  stall_req_mem,
    output logic                  mc_req,
    output logic                  mc_we,
    output logic [ADDR_W-1:0]     mc_addr,
    output logic [1:0]            mc_len,
    output logic [DATA_W-1:0]     mc_wdata,
    input  logic                  mc_done,
    input  logic [DATA_W-1:0]     mc_rdata,
    output logic [REG_ADDR_W-1:0] mem_reg_addr,
    output logic [DATA_W-1:0]     mem_reg_data,
    output logic                  if_write
);

    mem_state_e            state_q;
    mem_op_e               op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]     data_q;
    logic                  wb_en_q;
    logic                  mc_req_q;
    logic                  mc_we_q;
    logic [ADDR_W-1:0]     mc_addr_q;
    logic [1:0]            mc_len_q;
    logic [DATA_W-1:0]     mc_wdata_q;

    mem_op_e           ex_op;
    logic              ex_is_mem;
    logic [DATA_W-1:0] load_data_d;
    logic              unused_stall;

    assign ex_op        = mem_op_e'(ex_mem_op);
    assign ex_is_mem    = is_load(ex_op) || is_store(ex_op);
    assign unused_stall = ^{stall_in[5], stall_in[3:0]};

    mem_stage_load_extend u_load_extend (
        .op_i   (op_q),
        .rdata_i(mc_rdata),
        .data_o (load_data_d)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            op_q       <= MEM_NOP;
            rd_q       <= '0;
            data_q     <= '0;
            wb_en_q    <= 1'b0;
            mc_req_q   <= 1'b0;
            mc_we_q    <= 1'b0;
            mc_addr_q  <= '0;
            mc_len_q   <= LEN_BYTE;
            mc_wdata_q <= '0;
        end else if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (ex_is_mem) begin
                        op_q       <= ex_op;
                        rd_q       <= ex_reg_addr;
                        wb_en_q    <= is_load(ex_op) && (ex_reg_addr != '0);
                        mc_req_q   <= 1'b1;
                        mc_we_q    <= is_store(ex_op);
                        mc_addr_q  <= ex_mem_addr;
                        mc_len_q   <= op_len(ex_op);
                        mc_wdata_q <= align_wdata(ex_op, ex_store_data);
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mc_done) begin
                        data_q   <= load_data_d;
                        mc_req_q <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // EX_MEM advances on this same edge, so the op is not re-issued
                    if (!stall_in[4]) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mc_req   = mc_req_q;
    assign mc_we    = mc_we_q;
    assign mc_addr  = mc_addr_q;
    assign mc_len   = mc_len_q;
    assign mc_wdata = mc_wdata_q;

    always_comb begin
        stall_req_mem = 1'b0;
        mem_reg_addr  = '0;
        mem_reg_data  = '0;
        if_write      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_is_mem) begin
                    stall_req_mem = 1'b1;
                end else begin
                    mem_reg_addr = ex_reg_addr;
                    mem_reg_data = ex_reg_data;
                    if_write     = ex_if_write;
                end
            end
            ST_BUSY: stall_req_mem = 1'b1;
            ST_DONE: begin
                mem_reg_addr = rd_q;
                mem_reg_data = data_q;
                if_write     = wb_en_q;
            end
            default: stall_req_mem = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// transactions, compared against a transaction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [5:0]  stall_in;
    logic [4:0]  ex_reg_addr;
    logic [31:0] ex_reg_data;
    logic        ex_if_write;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic        stall_req_mem;
    logic        mc_req;
    logic        mc_we;
    logic [31:0] mc_addr;
    logic [1:0]  mc_len;
    logic [31:0] mc_wdata;
    logic        mc_done;
    logic [31:0] mc_rdata;
    logic [4:0]  mem_reg_addr;
    logic [31:0] mem_reg_data;
    logic        if_write;

    int vectors     = 0;
    int miscompares = 0;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .stall_in     (stall_in),
        .ex_reg_addr  (ex_reg_addr),
        .ex_reg_data  (ex_reg_data),
        .ex_if_write  (ex_if_write),
        .ex_mem_op    (ex_mem_op),
        .ex_mem_addr  (ex_mem_addr),
        .ex_store_data(ex_store_data),
        .stall_req_mem(stall_req_mem),
        .mc_req       (mc_req),
        .mc_we        (mc_we),
        .mc_addr      (mc_addr),
        .mc_len       (mc_len),
        .mc_wdata     (mc_wdata),
        .mc_done      (mc_done),
        .mc_rdata     (mc_rdata),
        .mem_reg_addr (mem_reg_addr),
        .mem_reg_data (mem_reg_data),
        .if_write     (if_write)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Reference model: access size and results derived from op semantics
    function automatic int op_bytes(input mem_op_e op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            default:                 return 4;
        endcase
    endfunction

    function automatic bit ref_is_load(input mem_op_e op);
        return op == MEM_LB || op == MEM_LH || op == MEM_LW || op == MEM_LBU || op == MEM_LHU;
    endfunction

    function automatic bit ref_is_store(input mem_op_e op);
        return op == MEM_SB || op == MEM_SH || op == MEM_SW;
    endfunction

    function automatic logic [31:0] ref_load(input mem_op_e op, input logic [31:0] rdata);
        logic [31:0] b;
        logic [31:0] h;
        b = rdata % 32'd256;
        h = rdata % 32'd65536;
        case (op)
            MEM_LB:  return (b >= 32'd128)   ? b - 32'd256   : b;
            MEM_LBU: return b;
            MEM_LH:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            MEM_LHU: return h;
            MEM_LW:  return rdata;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input mem_op_e op, input logic [31:0] sdata);
        if (op_bytes(op) == 4) return sdata;
        return sdata % (32'd1 << (8 * op_bytes(op)));
    endfunction

    task automatic drive_nop_and_check(input logic [4:0] rd, input logic [31:0] data, input logic we);
        ex_mem_op   = MEM_NOP;
        ex_reg_addr = rd;
        ex_reg_data = data;
        ex_if_write = we;
        ex_mem_addr = $urandom;
        #1;
        check("nop_addr",  32'(mem_reg_addr), 32'(rd));
        check("nop_data",  mem_reg_data, data);
        check("nop_we",    32'(if_write), 32'(we));
        check("nop_stall", 32'(stall_req_mem), 32'd0);
        check("nop_req",   32'(mc_req), 32'd0);
        tick();
    endtask

    task automatic run_mem(input mem_op_e op, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input int lat, input int hold);
        logic [31:0] exp_data;
        logic        exp_we;
        int          stalls;
        exp_data = ref_is_load(op) ? ref_load(op, rdata) : 32'd0;
        exp_we   = ref_is_load(op) && (rd != 5'd0);
        ex_mem_op     = op;
        ex_reg_addr   = rd;
        ex_reg_data   = $urandom;
        ex_if_write   = 1'b1;
        ex_mem_addr   = addr;
        ex_store_data = sdata;
        stalls = 0;
        #1;
        check("issue_we",   32'(if_write), 32'd0);
        check("issue_data", mem_reg_data, 32'd0);
        check("issue_req",  32'(mc_req), 32'd0);
        stalls += int'(stall_req_mem);
        tick();
        for (int i = 0; i <= lat; i++) begin
            mc_done  = (i == lat);
            mc_rdata = (i == lat) ? rdata : $urandom;
            #1;
            check("busy_req",  32'(mc_req), 32'd1);
            check("busy_we",   32'(mc_we), 32'(ref_is_store(op)));
            check("busy_addr", mc_addr, addr);
            check("busy_len",  32'(mc_len), 32'(op_bytes(op) - 1));
            if (ref_is_store(op)) check("busy_wdata", mc_wdata, ref_wdata(op, sdata));
            check("busy_bubble", 32'(if_write), 32'd0);
            stalls += int'(stall_req_mem);
            tick();
        end
        mc_done  = 1'b0;
        mc_rdata = $urandom;
        check("stall_cycles", 32'(stalls), 32'(lat + 2));
        for (int i = 0; i <= hold; i++) begin
            stall_in = (i < hold) ? 6'b010000 : 6'b000000;
            #1;
            check("done_stall", 32'(stall_req_mem), 32'd0);
            check("done_req",   32'(mc_req), 32'd0);
            check("done_rd",    32'(mem_reg_addr), 32'(rd));
            check("done_data",  mem_reg_data, exp_data);
            check("done_we",    32'(if_write), 32'(exp_we));
            tick();
        end
        stall_in  = 6'b0;
        ex_mem_op = MEM_NOP;
    endtask

    initial begin
        mem_op_e op;
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        stall_in      = 6'b0;
        ex_reg_addr   = 5'd0;
        ex_reg_data   = 32'd0;
        ex_if_write   = 1'b0;
        ex_mem_op     = MEM_NOP;
        ex_mem_addr   = 32'd0;
        ex_store_data = 32'd0;
        mc_done       = 1'b0;
        mc_rdata      = 32'd0;

        #2;
        check("rst_req",   32'(mc_req), 32'd0);
        check("rst_we",    32'(mc_we), 32'd0);
        check("rst_addr",  mc_addr, 32'd0);
        check("rst_len",   32'(mc_len), 32'd0);
        check("rst_wdata", mc_wdata, 32'd0);
        check("rst_stall", 32'(stall_req_mem), 32'd0);
        #10 rst_in = 1'b1;
        tick();

        drive_nop_and_check(5'd5, 32'h0000_1234, 1'b1);

        run_mem(MEM_LB,  5'd6, 32'h0000_0100, 32'h0, 32'h0000_0080, 2, 0);
        run_mem(MEM_LBU, 5'd6, 32'h0000_0100, 32'h0, 32'h0000_0080, 2, 0);
        run_mem(MEM_SH,  5'd7, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 1, 0);

        run_mem(MEM_LW,  5'd8, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 1, 2);
        drive_nop_and_check(5'd7, 32'h0BAD_F00D, 1'b1);

        run_mem(MEM_LH, 5'd0, 32'h0000_0011, 32'h0, 32'h0000_8001, 0, 0);

        // Frozen pipeline: masked done pulse in BUSY, then a frozen DONE exit
        ex_mem_op   = MEM_LH;
        ex_reg_addr = 5'd9;
        ex_mem_addr = 32'h0000_0300;
        tick();
        rdy_in   = 1'b0;
        mc_done  = 1'b1;
        mc_rdata = 32'h0000_0055;
        tick();
        rdy_in  = 1'b1;
        mc_done = 1'b0;
        #1;
        check("frz_req",   32'(mc_req), 32'd1);
        check("frz_stall", 32'(stall_req_mem), 32'd1);
        check("frz_we",    32'(if_write), 32'd0);
        tick();
        mc_done  = 1'b1;
        mc_rdata = 32'h1234_8000;
        tick();
        mc_done = 1'b0;
        rdy_in  = 1'b0;
        #1;
        check("frz_done_data", mem_reg_data, ref_load(MEM_LH, 32'h1234_8000));
        check("frz_done_we",   32'(if_write), 32'd1);
        tick();
        rdy_in = 1'b1;
        #1;
        check("frz_hold_rd",    32'(mem_reg_addr), 32'd9);
        check("frz_hold_stall", 32'(stall_req_mem), 32'd0);
        tick();
        drive_nop_and_check(5'd10, 32'h0000_00AA, 1'b0);

        for (int n = 0; n < 40; n++) begin
            op = mem_op_e'(4'($urandom_range(0, 8)));
            if (op == MEM_NOP)
                drive_nop_and_check(5'($urandom), $urandom, 1'($urandom));
            else
                run_mem(op, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
                        $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 2));
        end

        // Reset during BUSY must drop the request at once
        ex_mem_op   = MEM_LW;
        ex_reg_addr = 5'd3;
        ex_mem_addr = 32'h0000_0500;
        tick();
        #1;
        check("mid_busy_req", 32'(mc_req), 32'd1);
        #2 rst_in = 1'b0;
        #1;
        check("mid_rst_req",  32'(mc_req), 32'd0);
        check("mid_rst_we",   32'(if_write), 32'd0);
        check("mid_rst_addr", mc_addr, 32'd0);
        ex_mem_op = MEM_NOP;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) drive_nop_and_check(5'd4, 32'h0000_4444, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
